// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - access size/sign codes carried on pN_ctrl / mem_ctrl
//   - arbiter FSM state type
//   - default data-memory capacity in bytes
//   - ctrl_size(): byte count of an access code (0 for an unused code)
package dmem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  localparam logic [2:0] CTRL_LB  = 3'b000;
  localparam logic [2:0] CTRL_LH  = 3'b001;
  localparam logic [2:0] CTRL_LW  = 3'b010;
  localparam logic [2:0] CTRL_LBU = 3'b100;
  localparam logic [2:0] CTRL_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic [2:0] ctrl_size(input logic [2:0] ctrl);
    logic [2:0] sz;
    case (ctrl)
      CTRL_LB, CTRL_LBU: sz = 3'd1;
      CTRL_LH, CTRL_LHU: sz = 3'd2;
      CTRL_LW:           sz = 3'd4;
      default:           sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Legality check for one data-memory request.
// Ports:
//   addr    in  32  byte address
//   we      in  1   1 = store, 0 = load
//   ctrl    in  3   access size/sign code
//   illegal out 1   request must be rejected (bad code, signed-less store,
//                   misaligned half/word, or access running past MEM_BYTES)
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [2:0]  ctrl,
  output logic        illegal
);

  logic [2:0]  w_size;
  logic [32:0] w_end;

  always_comb begin
    w_size  = ctrl_size(ctrl);
    // 33-bit sum so an access near 0xFFFF_FFFF cannot wrap back into range
    w_end   = {1'b0, addr} + {30'b0, w_size};
    illegal = 1'b0;
    if (w_size == 3'd0)                      illegal = 1'b1;
    if (we && ctrl[2])                       illegal = 1'b1;
    if ((w_size == 3'd2) && addr[0])         illegal = 1'b1;
    if ((w_size == 3'd4) && (addr[1:0] != 2'b00)) illegal = 1'b1;
    if (w_end > 33'(MEM_BYTES))              illegal = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU = p0, DMA = p1) round-robin arbiter in front of a single
// data memory. One request is serviced at a time: accept (IDLE), memory
// access (ACCESS), response pulse (RESP).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pN_valid/pN_ready        request handshake (ready only in IDLE)
//   pN_addr/we/ctrl/wdata    request payload
//   pN_rvalid/rdata/err      one-cycle response
//   mem_addr/wdata/wr/ctrl   memory request, nonzero only in ACCESS
//   mem_rdata                combinational, already sized/extended read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [31:0] p0_addr,
  input  logic        p0_we,
  input  logic [2:0]  p0_ctrl,
  input  logic [31:0] p0_wdata,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [31:0] p1_addr,
  input  logic        p1_we,
  input  logic [2:0]  p1_ctrl,
  input  logic [31:0] p1_wdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata
);

  state_t      r_state, w_next;
  logic        r_last;
  logic        r_id;
  logic [31:0] r_addr;
  logic        r_we;
  logic [2:0]  r_ctrl;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_grant_any;
  logic        w_grant_id;
  logic [31:0] w_sel_addr;
  logic        w_sel_we;
  logic [2:0]  w_sel_ctrl;
  logic [31:0] w_sel_wdata;
  logic        w_illegal;

  dmem_req_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .addr   (r_addr),
    .we     (r_we),
    .ctrl   (r_ctrl),
    .illegal(w_illegal)
  );

  // On a tie the port not granted last wins; otherwise the lone requester.
  always_comb begin
    w_grant_any = p0_valid | p1_valid;
    w_grant_id  = (p0_valid && p1_valid) ? ~r_last : p1_valid;
    if (w_grant_id) begin
      w_sel_addr  = p1_addr;
      w_sel_we    = p1_we;
      w_sel_ctrl  = p1_ctrl;
      w_sel_wdata = p1_wdata;
    end else begin
      w_sel_addr  = p0_addr;
      w_sel_we    = p0_we;
      w_sel_ctrl  = p0_ctrl;
      w_sel_wdata = p0_wdata;
    end
  end

  // State register and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_ctrl  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_grant_any) begin
        r_last  <= w_grant_id;
        r_id    <= w_grant_id;
        r_addr  <= w_sel_addr;
        r_we    <= w_sel_we;
        r_ctrl  <= w_sel_ctrl;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == ST_ACCESS) begin
        r_rdata <= (!r_we && !w_illegal) ? mem_rdata : '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_any) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs; forced to zero while rst is high so an in-flight store or
  // response is suppressed in the same cycle the reset is applied.
  always_comb begin
    p0_ready  = 1'b0;
    p1_ready  = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    p0_err    = 1'b0;
    p1_err    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    mem_ctrl  = '0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          p0_ready = w_grant_any && !w_grant_id;
          p1_ready = w_grant_any &&  w_grant_id;
        end
        ST_ACCESS: begin
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
          mem_ctrl  = r_ctrl;
          mem_wr    = r_we && !w_illegal;
        end
        ST_RESP: begin
          if (r_id) begin
            p1_rvalid = 1'b1;
            p1_rdata  = r_rdata;
            p1_err    = w_illegal;
          end else begin
            p0_rvalid = 1'b1;
            p0_rdata  = r_rdata;
            p0_err    = w_illegal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array data memory, transaction-level reference
// model checked every cycle, directed scenarios with literal expectations,
// then randomized traffic with random resets.
module tb_dmem_arbiter;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
  logic [2:0]  p0_ctrl = '0, p1_ctrl = '0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;
  logic [2:0]  mem_ctrl;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;

  logic [7:0] phys   [MEM_BYTES];
  logic [7:0] shadow [MEM_BYTES];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_we(p0_we),
    .p0_ctrl(p0_ctrl), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_we(p1_we),
    .p1_ctrl(p1_ctrl), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
  );

  // ---------------- data memory (environment) ----------------
  logic [32:0] ea;
  logic [7:0]  b0, b1, b2, b3;
  assign ea = {1'b0, mem_addr};
  assign b0 = (ea        < 33'(MEM_BYTES)) ? phys[mem_addr[9:0]]           : 8'h00;
  assign b1 = (ea + 33'd1 < 33'(MEM_BYTES)) ? phys[10'(mem_addr + 32'd1)] : 8'h00;
  assign b2 = (ea + 33'd2 < 33'(MEM_BYTES)) ? phys[10'(mem_addr + 32'd2)] : 8'h00;
  assign b3 = (ea + 33'd3 < 33'(MEM_BYTES)) ? phys[10'(mem_addr + 32'd3)] : 8'h00;

  always_comb begin
    case (mem_ctrl)
      3'b000:  mem_rdata = {{24{b0[7]}}, b0};
      3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
      3'b010:  mem_rdata = {b3, b2, b1, b0};
      3'b100:  mem_rdata = {24'h0, b0};
      3'b101:  mem_rdata = {16'h0, b1, b0};
      default: mem_rdata = '0;
    endcase
  end

  initial begin
    logic [7:0] v;
    for (int i = 0; i < int'(MEM_BYTES); i++) begin
      v = 8'($urandom);
      phys[i]   = v;
      shadow[i] = v;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (mem_wr) begin
        for (int k = 0; k < 4; k++) begin
          if ((k == 0) || (k == 1 && mem_ctrl[1:0] != 2'b00) || (mem_ctrl[1:0] == 2'b10)) begin
            if (ea + 33'(k) < 33'(MEM_BYTES)) phys[10'(mem_addr + 32'(k))] = mem_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_wr) wr_cnt = wr_cnt + 1;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no DUT event within cycle budget (t=%0t)", name, $time);
  endtask

  function automatic int acc_size(input logic [2:0] c);
    case (c)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [31:0] a, input logic we, input logic [2:0] c);
    longint unsigned la;
    int sz;
    la = a;
    sz = acc_size(c);
    if (sz == 0) return 1;
    if (we && c >= 3'b100) return 1;
    if (la % longint'(sz) != 0) return 1;
    if (la + longint'(sz) > longint'(MEM_BYTES)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
    longint v;
    int sz;
    sz = acc_size(c);
    v  = 0;
    for (int k = 0; k < sz; k++) v = v + (longint'(shadow[int'(a) + k]) << (8 * k));
    if (c < 3'b100 && v >= (64'sd1 << (8 * sz - 1))) v = v - (64'sd1 << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
    int sz;
    sz = acc_size(c);
    for (int k = 0; k < sz; k++) shadow[int'(a) + k] = 8'(d >> (8 * k));
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    bit          id;
    bit          we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  initial begin
    txn_t t;
    bit active = 0;
    int age = 0;
    bit m_last = 1;
    bit gv, g;
    logic e_r0, e_r1, e_v0, e_v1, e_wr;
    logic [31:0] e_addr, e_wd;
    logic [2:0] e_ctrl;
    t = '{id: 0, we: 0, ctrl: '0, addr: '0, wdata: '0, rdata: '0, err: 0};
    forever begin
      @(negedge clk);
      e_r0 = 0; e_r1 = 0; e_v0 = 0; e_v1 = 0; e_wr = 0;
      e_addr = '0; e_wd = '0; e_ctrl = '0;
      gv = 0; g = 0;
      if (!rst) begin
        if (!active) begin
          if (p0_valid && p1_valid) begin gv = 1; g = !m_last; end
          else if (p0_valid)        begin gv = 1; g = 0; end
          else if (p1_valid)        begin gv = 1; g = 1; end
          e_r0 = gv && !g;
          e_r1 = gv && g;
        end else if (age == 1) begin
          e_addr = t.addr; e_wd = t.wdata; e_ctrl = t.ctrl;
          e_wr   = t.we && !t.err;
        end else begin
          e_v0 = !t.id;
          e_v1 = t.id;
        end
      end
      chk("ready",  32'({p1_ready, p0_ready}),   32'({e_r1, e_r0}));
      chk("rvalid", 32'({p1_rvalid, p0_rvalid}), 32'({e_v1, e_v0}));
      if (rst || e_v0) begin
        chk("p0_rdata", p0_rdata, rst ? 32'h0 : t.rdata);
        chk("p0_err", 32'(p0_err), rst ? 32'h0 : 32'(t.err));
      end
      if (rst || e_v1) begin
        chk("p1_rdata", p1_rdata, rst ? 32'h0 : t.rdata);
        chk("p1_err", 32'(p1_err), rst ? 32'h0 : 32'(t.err));
      end
      chk("mem_wr",    32'(mem_wr),   32'(e_wr));
      chk("mem_addr",  mem_addr,      e_addr);
      chk("mem_wdata", mem_wdata,     e_wd);
      chk("mem_ctrl",  32'(mem_ctrl), 32'(e_ctrl));
      // advance the model across the coming edge
      if (rst) begin
        active = 0;
        m_last = 1;
      end else if (!active) begin
        if (gv) begin
          t.id    = g;
          t.we    = g ? p1_we    : p0_we;
          t.ctrl  = g ? p1_ctrl  : p0_ctrl;
          t.addr  = g ? p1_addr  : p0_addr;
          t.wdata = g ? p1_wdata : p0_wdata;
          t.err   = ref_illegal(t.addr, t.we, t.ctrl);
          t.rdata = '0;
          active  = 1;
          age     = 1;
          m_last  = g;
        end
      end else if (age == 1) begin
        if (!t.err) begin
          if (t.we) ref_store(t.addr, t.ctrl, t.wdata);
          else      t.rdata = ref_load(t.addr, t.ctrl);
        end
        age = 2;
      end else begin
        active = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_port(input bit port, input bit v, input bit we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      p1_valid = v; p1_we = we; p1_ctrl = c; p1_addr = a; p1_wdata = d;
    end else begin
      p0_valid = v; p0_we = we; p0_ctrl = c; p0_addr = a; p0_wdata = d;
    end
  endtask

  // Issue one request on a port and wait for its response (bounded waits).
  task automatic txn(input bit port, input bit we, input logic [2:0] c, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rdata, output logic err,
                     output int lat);
    int t_acc;
    bit got;
    rdata = '0; err = 1'b1; lat = -1; t_acc = 0;
    set_port(port, 1, we, c, a, d);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_ready : p0_ready) begin got = 1; t_acc = cyc; end
    end
    @(posedge clk); #1;
    set_port(port, 0, 0, 3'b000, '0, '0);
    if (!got) begin timeout_fail("txn_accept"); return; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (port ? p1_rvalid : p0_rvalid) begin
        got = 1;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
        lat   = cyc - t_acc;
      end
    end
    @(posedge clk); #1;
    if (!got) timeout_fail("txn_response");
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h3FC + 32'($urandom_range(0, 3));
      1: begin
        case ($urandom_range(0, 3))
          0:       return 32'd1024;
          1:       return 32'hFFFF_FFFF;
          2:       return 32'hFFFF_FFFC;
          default: return 32'd1022;
        endcase
      end
      default: return 32'h80 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [2:0] rnd_ctrl();
    logic [2:0] legal [5];
    logic [2:0] bad [3];
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad   = '{3'b011, 3'b110, 3'b111};
    if ($urandom_range(0, 9) == 0) return bad[$urandom_range(0, 2)];
    return legal[$urandom_range(0, 4)];
  endfunction

  task automatic rnd_port(input bit port);
    logic [2:0]  c;
    logic [31:0] a;
    int sz;
    c  = rnd_ctrl();
    a  = rnd_addr();
    sz = acc_size(c);
    if (sz > 1 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
    set_port(port, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), c, a, $urandom);
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, wr0, rv;
    int gq[$];

    // reset state
    rst = 1;
    @(negedge clk);
    chk("rst_ctl", 32'({p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_wr}), 32'h0);
    chk("rst_p0_rdata", p0_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr | mem_wdata | 32'(mem_ctrl), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    // round-robin with both ports always requesting
    set_port(0, 1, 0, 3'b010, 32'h0, '0);
    set_port(1, 1, 0, 3'b010, 32'h4, '0);
    for (int i = 0; i < 40 && gq.size() < 4; i++) begin
      @(negedge clk);
      if (p0_ready) gq.push_back(0);
      if (p1_ready) gq.push_back(1);
    end
    @(posedge clk); #1;
    set_port(0, 0, 0, 3'b000, '0, '0);
    set_port(1, 0, 0, 3'b000, '0, '0);
    if (gq.size() < 4) timeout_fail("rr_grants");
    for (int i = 0; i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % 2));
    repeat (3) @(posedge clk);
    #1;

    // store word then load it from the other port
    wr0 = wr_cnt;
    txn(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_wr_cycles", 32'(wr_cnt - wr0), 32'd1);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", 32'(er), 32'h0);
    txn(1, 0, 3'b010, 32'h10, '0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'h0);
    chk("lw_latency", 32'(lat), 32'd2);

    // illegal requests
    wr0 = wr_cnt;
    txn(1, 0, 3'b001, 32'h21, '0, rd, er, lat);
    chk("lh_misalign_err", 32'(er), 32'h1);  chk("lh_misalign_rdata", rd, 32'h0);
    txn(0, 0, 3'b010, 32'h22, '0, rd, er, lat);
    chk("lw_misalign_err", 32'(er), 32'h1);  chk("lw_misalign_rdata", rd, 32'h0);
    txn(0, 1, 3'b010, 32'h3FE, 32'h1, rd, er, lat);
    chk("sw_range_err", 32'(er), 32'h1);     chk("sw_range_rdata", rd, 32'h0);
    txn(0, 0, 3'b011, 32'h0, '0, rd, er, lat);
    chk("ctrl011_err", 32'(er), 32'h1);      chk("ctrl011_rdata", rd, 32'h0);
    txn(0, 0, 3'b010, 32'hFFFF_FFFF, '0, rd, er, lat);
    chk("lw_wrap_err", 32'(er), 32'h1);
    txn(1, 1, 3'b100, 32'h30, 32'h5, rd, er, lat);
    chk("sbu_err", 32'(er), 32'h1);
    chk("illegal_wr_cycles", 32'(wr_cnt - wr0), 32'd0);
    txn(0, 0, 3'b010, 32'h3FC, '0, rd, er, lat);
    chk("lw_top_err", 32'(er), 32'h0);

    // byte / halfword sign handling
    txn(0, 1, 3'b000, 32'h40, 32'hABCDEF80, rd, er, lat);
    txn(0, 0, 3'b000, 32'h40, '0, rd, er, lat);
    chk("lb_sext", rd, 32'hFFFFFF80);
    txn(1, 0, 3'b100, 32'h40, '0, rd, er, lat);
    chk("lbu_zext", rd, 32'h00000080);
    txn(1, 1, 3'b001, 32'h44, 32'h12348001, rd, er, lat);
    txn(0, 0, 3'b001, 32'h44, '0, rd, er, lat);
    chk("lh_sext", rd, 32'hFFFF8001);
    txn(0, 0, 3'b101, 32'h44, '0, rd, er, lat);
    chk("lhu_zext", rd, 32'h00008001);

    // reset during the memory cycle of a store aborts it
    txn(0, 1, 3'b010, 32'h50, 32'h11223344, rd, er, lat);
    set_port(0, 1, 1, 3'b010, 32'h50, 32'h12345678);
    @(negedge clk);
    chk("abort_accept", 32'(p0_ready), 32'h1);
    wr0 = wr_cnt;
    @(posedge clk); #1;
    set_port(0, 0, 0, 3'b000, '0, '0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) rv++;
    end
    chk("abort_rvalid", 32'(rv), 32'h0);
    chk("abort_wr_cycles", 32'(wr_cnt - wr0), 32'h0);
    @(posedge clk); #1;
    txn(0, 0, 3'b010, 32'h50, '0, rd, er, lat);
    chk("abort_word", rd, 32'h11223344);

    // p0 waits while p1 is in service; it is latched with the idle-cycle payload
    txn(0, 1, 3'b010, 32'h60, 32'h0, rd, er, lat);
    txn(0, 1, 3'b010, 32'h64, 32'h0, rd, er, lat);
    txn(0, 1, 3'b010, 32'h68, 32'h0, rd, er, lat);
    set_port(1, 1, 0, 3'b010, 32'h10, '0);
    @(negedge clk);
    chk("hold_p1_ready", 32'(p1_ready), 32'h1);
    @(posedge clk); #1;
    set_port(1, 0, 0, 3'b000, '0, '0);
    set_port(0, 1, 1, 3'b010, 32'h60, 32'hAAAAAAAA);
    @(negedge clk);
    chk("hold_ready_access", 32'(p0_ready), 32'h0);
    @(posedge clk); #1;
    set_port(0, 1, 1, 3'b010, 32'h64, 32'h5555AAAA);
    @(negedge clk);
    chk("hold_ready_resp", 32'(p0_ready), 32'h0);
    @(posedge clk); #1;
    set_port(0, 1, 1, 3'b010, 32'h68, 32'h0BADCAFE);
    @(negedge clk);
    chk("hold_ready_idle", 32'(p0_ready), 32'h1);
    @(posedge clk); #1;
    set_port(0, 0, 0, 3'b000, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    txn(1, 0, 3'b010, 32'h68, '0, rd, er, lat);
    chk("hold_word68", rd, 32'h0BADCAFE);
    txn(1, 0, 3'b010, 32'h60, '0, rd, er, lat);
    chk("hold_word60", rd, 32'h0);
    txn(1, 0, 3'b010, 32'h64, '0, rd, er, lat);
    chk("hold_word64", rd, 32'h0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rnd_port(0);
      rnd_port(1);
      rst = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    rst = 0;
    set_port(0, 0, 0, 3'b000, '0, '0);
    set_port(1, 0, 0, 3'b000, '0, '0);
    repeat (6) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, byte capacity of the shared data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 pN_valid  input  1  requester N (N=0 CPU, N=1 DMA) presents a request.
REQ-005 pN_ready  output  1  requester N's request accepted this cycle.
REQ-006 pN_addr  input  32  byte address.
REQ-007 pN_we  input  1  1=store, 0=load.
REQ-008 pN_ctrl  input  3  access size/sign code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
REQ-009 pN_wdata  input  32  store data, little-endian, low bytes used for SB/SH.
REQ-010 pN_rvalid  output  1  one-cycle response pulse for requester N.
REQ-011 pN_rdata  output  32  load result, valid with pN_rvalid.
REQ-012 pN_err  output  1  request rejected, valid with pN_rvalid.
REQ-013 mem_addr  output  32  address to data memory.
REQ-014 mem_wdata  output  32  store data to data memory.
REQ-015 mem_wr  output  1  memory write enable.
REQ-016 mem_ctrl  output  3  access code to data memory.
REQ-017 mem_rdata  input  32  combinational read data from data memory, already sized/extended per mem_ctrl.

Function
REQ-018 The block shall use the FSM states IDLE, ACCESS and RESP.
REQ-019 In IDLE with any pN_valid high, it shall assert exactly one pN_ready, latch that requester's addr/we/ctrl/wdata and requester ID, and move to ACCESS.
REQ-020 If only one valid is high, it shall grant that one. If both are high, it shall grant the requester not granted last (round-robin).
REQ-021 The last-granted pointer shall update only on a grant.
REQ-022 pN_ready shall be high only in IDLE and never in ACCESS or RESP; requesters hold valid and payload until ready.
REQ-023 In ACCESS it shall drive mem_addr/mem_ctrl/mem_wdata from the latched request.
REQ-024 In ACCESS, for a legal store, it shall assert mem_wr for exactly that one cycle; for a legal load, it shall register mem_rdata at the end of the cycle. It shall then move to RESP.
REQ-025 In RESP it shall pulse rvalid for the latched requester only, with rdata (0 for stores) and err, then return to IDLE.
REQ-026 Latency shall be: accept cycle T, memory cycle T+1, rvalid at T+2. A new grant is possible at T+3.
REQ-027 A request is illegal on any of:
  - ctrl in {011,110,111};
  - store with ctrl 100 or 101;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=00;
  - addr+size > MEM_BYTES.
REQ-028 For an illegal request in ACCESS, mem_wr shall stay 0; RESP shall give err=1 and rdata=0.
REQ-029 Outside ACCESS, mem_wr shall be 0 and mem_addr/mem_wdata/mem_ctrl shall be 0.
REQ-030 Size checks shall use 33-bit arithmetic so that addr+size does not wrap; address 0xFFFF_FFFF with LW is an error.

Reset
REQ-031 With rst high at a rising edge, the block shall go to IDLE, clear latched request and read register, and set the last-granted pointer so port 0 wins the next tie.
REQ-032 During a rst-high cycle, all outputs shall be 0: pN_ready, pN_rvalid, pN_err, pN_rdata, and all mem_* outputs.
REQ-033 Reset in ACCESS or RESP shall abort: no write issued, no rvalid emitted.

Structure
REQ-034 Package dmem_pkg shall hold the ctrl encodings (LB, LH, LW, LBU, LHU), the state enum and the default MEM_BYTES.
REQ-035 Legality checking shall be a sub-module dmem_req_check (inputs addr/we/ctrl, output illegal), instantiated once on the latched request.

Verification
REQ-036 p0 SW addr 0x10 data 0xDEADBEEF, then p1 LW 0x10 -> mem_wr high exactly one cycle; p1_rvalid at T+2 with rdata 0xDEADBEEF, err 0.
REQ-037 p0 and p1 valid every cycle for 4 grants after reset -> grant order p0,p1,p0,p1; each ready a single cycle.
REQ-038 p1 LH 0x21, p0 LW 0x22, p0 SW addr 0x3FE (MEM_BYTES 1024), p0 ctrl 011 -> each gives err=1, rdata 0, mem_wr never high.
REQ-039 Store byte 0x80 at 0x40, then LB 0x40 -> rdata 0xFFFFFF80; LBU 0x40 -> rdata 0x00000080.
REQ-040 rst asserted in ACCESS cycle of SW 0x50 data 0x12345678, then LW 0x50 -> mem_wr never high for the aborted store, no rvalid from it, word unchanged.
REQ-041 p0 valid held with payload changing while p1 is in service -> p0 accepted only in next IDLE with the payload present in that cycle.
